alu_chain_ctrl: RTL and testbench
=================================

ALU_CHAIN_CTRL -- requirements
Module: alu_chain_ctrl

Interface
REQ-001 SHALL have parameter NWORDS, default 4, number of 16-bit words per operand (legal 1..4); W = 16*NWORDS.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  request valid.
REQ-005 SHALL have port in_ready  output  1  request accepted when in_valid & in_ready.
REQ-006 SHALL have port in_op  input  3  ALU op code: 000 ADD, 001 OR, 010 ADC, 011 SBB, 100 AND, 101 SUB, 110 XOR, 111 CMP.
REQ-007 SHALL have port in_cin  input  1  carry/borrow-in for ADC/SBB requests.
REQ-008 SHALL have ports in_a, in_b  input  W  operands.
REQ-009 SHALL have ports alu_opA, alu_opB  output  16  word operands to the 16-bit ALU.
REQ-010 SHALL have port alu_op  output  3  ALU op code.
REQ-011 SHALL have port alu_cin  output  1  ALU carry-in.
REQ-012 SHALL have ports alu_r  input  16, alu_cf, alu_af, alu_of  input  1  combinational ALU result and flags, same cycle.
REQ-013 SHALL have port out_valid  output  1  result valid.
REQ-014 SHALL have port out_ready  input  1  result consumed when out_valid & out_ready.
REQ-015 SHALL have port out_r  output  W  result.
REQ-016 SHALL have ports out_cf, out_af, out_of, out_zf, out_sf  output  1  result flags.

Function
REQ-017 SHALL implement FSM IDLE -> ISSUE -> DONE -> IDLE; in_ready = 1 only in IDLE.
REQ-018 SHALL on accept latch in_op, in_cin, in_a, in_b, clear word index k to 0, enter ISSUE.
REQ-019 SHALL in ISSUE drive word k (bits 16k+15:16k) on alu_opA/alu_opB, capture alu_r into result word k and alu flags at the clock edge, increment k; leave ISSUE after word NWORDS-1.
REQ-020 SHALL map ops: ADD word 0 = 000, words >0 = 010; SUB word 0 = 101, words >0 = 011; CMP word 0 = 111, words >0 = 011; ADC all words 010; SBB all words 011; AND/OR/XOR same op every word.
REQ-021 SHALL drive alu_cin: word 0 = latched in_cin for ADC/SBB else 0; words >0 = alu_cf captured from previous word for arithmetic ops, 0 for logical ops.
REQ-022 SHALL in IDLE and DONE drive alu_opA = alu_opB = 0, alu_op = 000, alu_cin = 0.
REQ-023 SHALL set out_valid = 1 in DONE only; latency accept-to-out_valid = NWORDS+1 cycles.
REQ-024 SHALL set out_r = assembled result words, except CMP: out_r = latched in_a (difference discarded, flags kept).
REQ-025 SHALL set out_cf, out_of = flags of word NWORDS-1 for arithmetic ops; 0 for AND/OR/XOR.
REQ-026 SHALL set out_af = alu_af of word 0 for arithmetic ops, 0 for logical.
REQ-027 SHALL set out_zf = 1 iff all NWORDS ALU result words were zero (CMP included); out_sf = bit 15 of the last ALU result word.
REQ-028 SHALL hold all out_* stable while out_valid & ~out_ready; DONE -> IDLE on out_ready; no back-to-back accept in the DONE cycle.
REQ-029 SHALL ignore in_valid outside IDLE; latched request unaffected by input changes after accept.

Reset
REQ-030 SHALL, while rst = 1 at a clock edge, enter IDLE, abort any operation, clear k, result and flag registers; after reset out_valid = 0, out_r = 0, all out flags = 0, in_ready = 1, ALU drive per REQ-022.
REQ-031 SHALL give rst priority over accept, issue and out handshake in the same cycle.

Verification
REQ-032 ADD a=0x0000_0000_0000_FFFF, b=1 -> alu_op 000,010,010,010; word-1 alu_cin=1; out_r=0x0000_0000_0001_0000, cf=0, zf=0, out_valid 5 cycles after accept.
REQ-033 ADD a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> out_r=0, cf=1, zf=1, of=0, sf=0.
REQ-034 SUB a=0, b=1 -> alu_op 101,011,011,011; out_r=0xFFFF_FFFF_FFFF_FFFF, cf=1, sf=1, zf=0, of=0.
REQ-035 CMP a=0x8000_0000_0000_0000, b=1 -> out_r=0x8000_0000_0000_0000, of=1, cf=0, zf=0, sf=0.
REQ-036 XOR a=b=0x1234_5678_9ABC_DEF0, out_ready held 0 for 5 cycles -> out_r=0, zf=1, cf=of=0; out_* stable, in_ready=0, extra in_valid pulse ignored.
REQ-037 rst asserted during word-2 issue -> next cycle out_valid=0, in_ready=1, alu_op=000, out_r=0; fresh request then completes correctly.

Source files
------------

// File: rtl/alu_chain_ctrl.sv
// alu_chain_ctrl: runs one W-bit ALU request through an external 16-bit ALU, one word
// per cycle from least to most significant, chaining carry/borrow between words.
module alu_chain_ctrl #(
  parameter int NWORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             in_op,
  input  logic                   in_cin,
  input  logic [16*NWORDS-1:0]   in_a,
  input  logic [16*NWORDS-1:0]   in_b,
  output logic [15:0]            alu_opA,
  output logic [15:0]            alu_opB,
  output logic [2:0]             alu_op,
  output logic                   alu_cin,
  input  logic [15:0]            alu_r,
  input  logic                   alu_cf,
  input  logic                   alu_af,
  input  logic                   alu_of,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [16*NWORDS-1:0]   out_r,
  output logic                   out_cf,
  output logic                   out_af,
  output logic                   out_of,
  output logic                   out_zf,
  output logic                   out_sf
);
  localparam int W  = 16 * NWORDS;
  localparam int KW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NWORDS - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_ADC = 3'b010;
  localparam logic [2:0] OP_SBB = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_CMP = 3'b111;

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t         state, state_nxt;
  logic [KW-1:0]  k;
  logic [2:0]     op_q;
  logic           cin_q;
  logic [W-1:0]   a_q, b_q, res_q;
  logic           cf_q, af_q, of_q, zf_q, sf_q;
  logic           accept, first_word, last_word, arith;

  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_ADC) || (op == OP_SBB) ||
           (op == OP_SUB) || (op == OP_CMP);
  endfunction

  // Upper words of ADD/SUB/CMP continue the chain with the carry-consuming ops.
  function automatic logic [2:0] word_op(input logic [2:0] op, input logic first);
    logic [2:0] w;
    case (op)
      OP_ADD:  w = first ? OP_ADD : OP_ADC;
      OP_SUB:  w = first ? OP_SUB : OP_SBB;
      OP_CMP:  w = first ? OP_CMP : OP_SBB;
      default: w = op;
    endcase
    return w;
  endfunction

  function automatic logic word_cin(input logic [2:0] op, input logic first,
                                    input logic cin, input logic cf);
    if (first) return ((op == OP_ADC) || (op == OP_SBB)) ? cin : 1'b0;
    return is_arith(op) ? cf : 1'b0;
  endfunction

  assign accept     = in_valid && in_ready;
  assign first_word = (k == '0);
  assign last_word  = (k == KLAST);
  assign arith      = is_arith(op_q);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = ISSUE;
      ISSUE:   if (last_word) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    alu_opA   = '0;
    alu_opB   = '0;
    alu_op    = 3'b000;
    alu_cin   = 1'b0;
    if (state == ISSUE) begin
      alu_opA = a_q[{k, 4'b0000} +: 16];
      alu_opB = b_q[{k, 4'b0000} +: 16];
      alu_op  = word_op(op_q, first_word);
      alu_cin = word_cin(op_q, first_word, cin_q, cf_q);
    end
  end

  // Request latch and per-word capture of the ALU result and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      k     <= '0;
      op_q  <= '0;
      cin_q <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      cf_q  <= 1'b0;
      af_q  <= 1'b0;
      of_q  <= 1'b0;
      zf_q  <= 1'b0;
      sf_q  <= 1'b0;
    end else if (accept) begin
      op_q  <= in_op;
      cin_q <= in_cin;
      a_q   <= in_a;
      b_q   <= in_b;
      k     <= '0;
    end else if (state == ISSUE) begin
      res_q[{k, 4'b0000} +: 16] <= alu_r;
      cf_q <= alu_cf;
      of_q <= alu_of;
      sf_q <= alu_r[15];
      if (first_word) begin
        af_q <= alu_af;
        zf_q <= (alu_r == 16'h0000);
      end else begin
        zf_q <= zf_q && (alu_r == 16'h0000);
      end
      k <= last_word ? '0 : k + KW'(1);
    end
  end

  assign out_r  = (op_q == OP_CMP) ? a_q : res_q;
  assign out_cf = arith && cf_q;
  assign out_of = arith && of_q;
  assign out_af = arith && af_q;
  assign out_zf = zf_q;
  assign out_sf = sf_q;

endmodule

// File: tb/tb_alu_chain_ctrl.sv
// Bench for alu_chain_ctrl: behavioural 16-bit ALU, W-bit reference model,
// directed literal cases plus randomized traffic checked every cycle.
module tb_alu_chain_ctrl;
  localparam int NWORDS = 4;
  localparam int W = 16 * NWORDS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [2:0] in_op = 3'b000;
  logic in_cin = 1'b0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic [15:0] alu_opA, alu_opB, alu_r;
  logic [2:0] alu_op;
  logic alu_cin, alu_cf, alu_af, alu_of;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [W-1:0] out_r;
  logic out_cf, out_af, out_of, out_zf, out_sf;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_chain_ctrl #(.NWORDS(NWORDS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_cin(in_cin), .in_a(in_a), .in_b(in_b),
    .alu_opA(alu_opA), .alu_opB(alu_opB), .alu_op(alu_op), .alu_cin(alu_cin),
    .alu_r(alu_r), .alu_cf(alu_cf), .alu_af(alu_af), .alu_of(alu_of),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r),
    .out_cf(out_cf), .out_af(out_af), .out_of(out_of), .out_zf(out_zf), .out_sf(out_sf)
  );

  // External 16-bit ALU seen by the controller.
  logic [16:0] alu_s;
  logic [4:0]  alu_n;
  logic        alu_c;
  always_comb begin
    alu_c  = ((alu_op == 3'b010) || (alu_op == 3'b011)) ? alu_cin : 1'b0;
    alu_s  = '0;
    alu_n  = '0;
    alu_r  = '0;
    alu_cf = 1'b0;
    alu_af = 1'b0;
    alu_of = 1'b0;
    case (alu_op)
      3'b000, 3'b010: begin
        alu_s  = {1'b0, alu_opA} + {1'b0, alu_opB} + {16'b0, alu_c};
        alu_n  = {1'b0, alu_opA[3:0]} + {1'b0, alu_opB[3:0]} + {4'b0, alu_c};
        alu_r  = alu_s[15:0];
        alu_cf = alu_s[16];
        alu_af = alu_n[4];
        alu_of = (alu_opA[15] == alu_opB[15]) && (alu_s[15] != alu_opA[15]);
      end
      3'b011, 3'b101, 3'b111: begin
        alu_s  = {1'b0, alu_opA} - {1'b0, alu_opB} - {16'b0, alu_c};
        alu_n  = {1'b0, alu_opA[3:0]} - {1'b0, alu_opB[3:0]} - {4'b0, alu_c};
        alu_r  = alu_s[15:0];
        alu_cf = alu_s[16];
        alu_af = alu_n[4];
        alu_of = (alu_opA[15] != alu_opB[15]) && (alu_s[15] != alu_opA[15]);
      end
      3'b001:  alu_r = alu_opA | alu_opB;
      3'b100:  alu_r = alu_opA & alu_opB;
      default: alu_r = alu_opA ^ alu_opB;
    endcase
  end

  typedef struct packed {
    logic [W-1:0] r;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         cin, cf, af, of, zf, sf;
  } exp_t;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic is_logic_op(input logic [2:0] op);
    return (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
  endfunction

  // Whole-operand reference: the W-bit result the chained words must add up to.
  function automatic exp_t model(input logic [2:0] op, input logic c,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t m;
    logic [W:0] full;
    logic [4:0] nib;
    logic [W-1:0] r;
    logic c0;
    m = '0;
    m.op = op; m.cin = c; m.a = a; m.b = b;
    c0 = ((op == 3'b010) || (op == 3'b011)) ? c : 1'b0;
    full = '0; nib = '0; r = '0;
    case (op)
      3'b000, 3'b010: begin
        full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c0};
        nib  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, c0};
        r = full[W-1:0];
        m.cf = full[W];
        m.af = nib[4];
        m.of = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      3'b011, 3'b101, 3'b111: begin
        full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, c0};
        r = full[W-1:0];
        m.cf = full[W];
        m.af = ({1'b0, a[3:0]} < ({1'b0, b[3:0]} + {4'b0, c0}));
        m.of = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      3'b001:  r = a | b;
      3'b100:  r = a & b;
      default: r = a ^ b;
    endcase
    m.zf = (r == '0);
    m.sf = r[W-1];
    m.r  = (op == 3'b111) ? a : r;
    return m;
  endfunction

  function automatic logic [2:0] exp_word_op(input logic [2:0] op, input logic first);
    case (op)
      3'b000:  return first ? 3'b000 : 3'b010;
      3'b101:  return first ? 3'b101 : 3'b011;
      3'b111:  return first ? 3'b111 : 3'b011;
      default: return op;
    endcase
  endfunction

  // Carry/borrow into word kk = carry out of the low 16*kk bits of the whole operation.
  function automatic logic exp_cin(input exp_t e, input int kk);
    logic [W:0] mask, la, lb, s;
    logic c0;
    c0 = ((e.op == 3'b010) || (e.op == 3'b011)) ? e.cin : 1'b0;
    if (kk == 0) return c0;
    if (is_logic_op(e.op)) return 1'b0;
    mask = ({{W{1'b0}}, 1'b1} << (16 * kk)) - 1'b1;
    la = {1'b0, e.a} & mask;
    lb = {1'b0, e.b} & mask;
    if ((e.op == 3'b000) || (e.op == 3'b010)) begin
      s = la + lb + {{W{1'b0}}, c0};
      return s[16 * kk];
    end
    return la < (lb + {{W{1'b0}}, c0});
  endfunction

  // Cycle-by-cycle comparison against the model.
  exp_t cur;
  bit   busy = 0;
  bit   just_rst = 0;
  int   since = 0;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      busy = 0;
      just_rst = 1;
    end else if (busy) begin
      since++;
      chk("in_ready_busy", in_ready, 0);
      if (since <= NWORDS) begin
        chk("out_valid_issue", out_valid, 0);
        chk("issue_op", alu_op, exp_word_op(cur.op, since == 1));
        chk("issue_opA", alu_opA, cur.a[16*(since-1) +: 16]);
        chk("issue_opB", alu_opB, cur.b[16*(since-1) +: 16]);
        chk("issue_cin", alu_cin, exp_cin(cur, since - 1));
      end else begin
        chk("out_valid_done", out_valid, 1);
        chk("out_r", out_r, cur.r);
        chk("out_flags", {out_cf, out_af, out_of, out_zf, out_sf},
            {cur.cf, cur.af, cur.of, cur.zf, cur.sf});
        chk("alu_idle_done", {alu_op, alu_cin, alu_opA, alu_opB}, 0);
        if (out_ready) busy = 0;
      end
    end else begin
      chk("in_ready_idle", in_ready, 1);
      chk("out_valid_idle", out_valid, 0);
      chk("alu_idle", {alu_op, alu_cin, alu_opA, alu_opB}, 0);
      if (just_rst) begin
        chk("reset_out_r", out_r, 0);
        chk("reset_flags", {out_cf, out_af, out_of, out_zf, out_sf}, 0);
      end
      if (in_valid) begin
        cur = model(in_op, in_cin, in_a, in_b);
        busy = 1;
        since = 0;
        just_rst = 0;
      end
    end
  end

  task automatic wait_idle();
    int n;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_idle", in_ready, 1);
    out_ready = 1'b0;
  endtask

  // ef = {cf, af, of, zf, sf}
  task automatic run_op(input string nm, input logic [2:0] op, input logic c,
                        input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                        input logic [W-1:0] er, input logic [4:0] ef);
    exp_t m;
    int n;
    m = model(op, c, a, b);
    chk({nm, "_model_r"}, m.r, er);
    chk({nm, "_model_flags"}, {m.cf, m.af, m.of, m.zf, m.sf}, ef);
    wait_idle();
    in_op = op; in_cin = c; in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = {$urandom, $urandom};
    in_b = ~b;
    in_op = 3'($urandom);
    in_cin = ~c;
    n = 1;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_latency"}, n, NWORDS + 1);
    for (int i = 0; i < hold; i++) begin
      in_valid = (i == 2);
      @(posedge clk); #1;
      chk({nm, "_hold_in_ready"}, in_ready, 0);
    end
    in_valid = 1'b0;
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_r"}, out_r, er);
    chk({nm, "_flags"}, {out_cf, out_af, out_of, out_zf, out_sf}, ef);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, "_released"}, {in_ready, out_valid}, 2'b10);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_r", out_r, 0);
    chk("rst_flags", {out_cf, out_af, out_of, out_zf, out_sf}, 0);
    chk("rst_alu", {alu_op, alu_cin, alu_opA, alu_opB}, 0);

    run_op("add_carry", 3'b000, 1'b0, 64'h0000_0000_0000_FFFF, 64'h1, 0,
           64'h0000_0000_0001_0000, 5'b01000);
    run_op("add_wrap", 3'b000, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 0,
           64'h0, 5'b11010);
    run_op("sub_borrow", 3'b101, 1'b0, 64'h0, 64'h1, 0,
           64'hFFFF_FFFF_FFFF_FFFF, 5'b11001);
    run_op("cmp_ovf", 3'b111, 1'b0, 64'h8000_0000_0000_0000, 64'h1, 0,
           64'h8000_0000_0000_0000, 5'b01100);
    run_op("xor_hold", 3'b110, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 5,
           64'h0, 5'b00010);
    run_op("adc_cin", 3'b010, 1'b1, 64'h0000_0000_0000_FFFF, 64'h0, 0,
           64'h0000_0000_0001_0000, 5'b01000);

    // Abort in the middle of the word-2 issue cycle.
    wait_idle();
    in_op = 3'b000; in_cin = 1'b0; in_a = 64'h1111_2222_3333_4444;
    in_b = 64'h5555_6666_7777_8888; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_word2_op", {alu_op, alu_opA}, {3'b010, 16'h2222});
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_alu_op", alu_op, 0);
    chk("abort_out_r", out_r, 0);
    run_op("after_abort", 3'b000, 1'b0, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 0,
           64'h6666_8888_AAAA_CCCC, 5'b00000);

    for (int i = 0; i < 600; i++) begin
      in_valid = ($urandom % 3) != 0;
      in_op = 3'($urandom);
      in_cin = 1'($urandom);
      case ($urandom % 4)
        0:       in_a = '1;
        1:       in_a = '0;
        default: in_a = {$urandom, $urandom};
      endcase
      case ($urandom % 4)
        0:       in_b = 64'h1;
        1:       in_b = '0;
        default: in_b = {$urandom, $urandom};
      endcase
      out_ready = ($urandom % 4) != 0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
